// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state encoding and the output FIFO depth used by the issue rule.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        SIdle  = 2'd0,
        SRun   = 2'd1,
        SDrain = 2'd2,
        SDone  = 2'd3
    } state_t;

    // Output buffer depth; the issue rule keeps buffered + in-flight words at or below this.
    localparam int CFifoDepth = 2;

endpackage

// File: rtl/ram_stream_rd_if.sv
// RAM port bus plus output stream of the RAM stream reader.
// Latency: n/a (wiring only).
// Backpressure: AStrReady from the consumer; the RAM port has none.
// Ports: master = reader side (drives RAM address/enables, stream data/valid);
//        slave  = RAM + consumer side (drives read data and stream ready).
interface ram_stream_rd_if #(
    parameter int CAddrLen = 11,
    parameter int CDataLen = 8
);
    logic [CAddrLen-1:0] ARamAddr;
    logic                ARamRdEn;
    logic                ARamWrEn;
    logic [CDataLen-1:0] ARamMosi;
    logic [CDataLen-1:0] ARamMiso;
    logic [CDataLen-1:0] AStrData;
    logic                AStrValid;
    logic                AStrReady;

    modport master (
        output ARamAddr, ARamRdEn, ARamWrEn, ARamMosi, AStrData, AStrValid,
        input  ARamMiso, AStrReady
    );

    modport slave (
        input  ARamAddr, ARamRdEn, ARamWrEn, ARamMosi, AStrData, AStrValid,
        output ARamMiso, AStrReady
    );
endinterface

// File: rtl/ram_stream_fifo2.sv
// Two-entry register FIFO buffering RAM read data ahead of the stream output.
// Latency: push visible at the head one cycle later; head is a register output.
// Backpressure: none internally; the caller never pushes into a full FIFO without a pop.
// Ports: AClkA/AResetAN/AClkAEn, APush/APushData in, APop in, AHeadData/ACount out.
module ram_stream_fifo2 #(
    parameter int CDataLen = 8
) (
    input  logic                AClkA,
    input  logic                AResetAN,
    input  logic                AClkAEn,
    input  logic                APush,
    input  logic [CDataLen-1:0] APushData,
    input  logic                APop,
    output logic [CDataLen-1:0] AHeadData,
    output logic [1:0]          ACount
);
    logic [CDataLen-1:0] rMem [2];
    logic                rWrPtr;
    logic                rRdPtr;
    logic [1:0]          rCount;
    logic                doPush;
    logic                doPop;

    // Guards keep pointers consistent even if a caller misbehaves.
    assign doPop  = APop && (rCount != 2'd0);
    assign doPush = APush && ((rCount != 2'd2) || doPop);

    always_ff @(posedge AClkA or negedge AResetAN) begin
        if (!AResetAN) begin
            rMem[0] <= '0;
            rMem[1] <= '0;
            rWrPtr  <= 1'b0;
            rRdPtr  <= 1'b0;
            rCount  <= 2'd0;
        end else if (AClkAEn) begin
            if (doPush) begin
                rMem[rWrPtr] <= APushData;
                rWrPtr       <= ~rWrPtr;
            end
            if (doPop) begin
                rRdPtr <= ~rRdPtr;
            end
            rCount <= rCount + 2'(doPush) - 2'(doPop);
        end
    end

    assign AHeadData = rMem[rRdPtr];
    assign ACount    = rCount;
endmodule

// File: rtl/ram_stream_rd.sv
// Sequential RAM reader: takes (address, length) and streams the words out in address order.
// Latency: start edge 0 -> first read cycle 1 -> first stream word cycle 3; one word/clock when ready.
// Backpressure: full valid/ready; reads stop once buffered + in-flight words would exceed 2.
// Ports: AClkA/AResetAN/AClkAEn; ACmdStart/ACmdAddr/ACmdLen command; ABusy/ADone status;
//        ABus = RAM port (address, read enable, read data) and output stream (data/valid/ready).
module ram_stream_rd
    import ram_stream_pkg::*;
#(
    parameter int CAddrLen = 11,
    parameter int CDataLen = 8
) (
    input  logic                AClkA,
    input  logic                AResetAN,
    input  logic                AClkAEn,
    input  logic                ACmdStart,
    input  logic [CAddrLen-1:0] ACmdAddr,
    input  logic [CAddrLen:0]   ACmdLen,
    output logic                ABusy,
    output logic                ADone,
    ram_stream_rd_if.master     ABus
);
    localparam logic [2:0]        CDepth3 = 3'(CFifoDepth);
    localparam logic [CAddrLen:0] COne    = (CAddrLen+1)'(1);

    state_t              rState;
    logic [CAddrLen-1:0] rAddr;
    logic [CAddrLen:0]   rRemain;
    logic                rInFlight;
    logic                rBusy;
    logic                rDone;

    logic [CDataLen-1:0] fifoHead;
    logic [1:0]          fifoCount;
    logic                strValid;
    logic                pop;
    logic [2:0]          occ;
    logic                issue;
    logic                drainEmpty;

    assign strValid = (fifoCount != 2'd0);
    assign pop      = strValid && ABus.AStrReady;

    // Words buffered plus the one landing from the RAM; a pop this edge frees a slot,
    // so a new read is only issued when its data is guaranteed a place at capture time.
    assign occ   = {1'b0, fifoCount} + {2'b00, rInFlight};
    assign issue = (rState == SRun) && (occ < (CDepth3 + {2'b00, pop}));

    // Last word leaves at this edge with nothing still coming back from the RAM.
    assign drainEmpty = !rInFlight &&
                        ((fifoCount == 2'd0) || ((fifoCount == 2'd1) && pop));

    always_ff @(posedge AClkA or negedge AResetAN) begin
        if (!AResetAN) begin
            rState    <= SIdle;
            rAddr     <= '0;
            rRemain   <= '0;
            rInFlight <= 1'b0;
            rBusy     <= 1'b0;
            rDone     <= 1'b0;
        end else if (AClkAEn) begin
            rInFlight <= issue;
            rDone     <= 1'b0;
            if (issue) begin
                rAddr   <= rAddr + CAddrLen'(1);
                rRemain <= rRemain - COne;
            end
            case (rState)
                SIdle: begin
                    if (ACmdStart) begin
                        rBusy <= 1'b1;
                        if (ACmdLen == '0) begin
                            rState <= SDone;
                            rDone  <= 1'b1;
                        end else begin
                            rState  <= SRun;
                            rAddr   <= ACmdAddr;
                            rRemain <= ACmdLen;
                        end
                    end
                end
                SRun: begin
                    if (issue && (rRemain == COne)) begin
                        rState <= SDrain;
                    end
                end
                SDrain: begin
                    if (drainEmpty) begin
                        rState <= SDone;
                        rDone  <= 1'b1;
                    end
                end
                SDone: begin
                    rState <= SIdle;
                    rBusy  <= 1'b0;
                end
                default: rState <= SIdle;
            endcase
        end
    end

    // In-flight data is on ARamMiso now and is captured at this enabled edge.
    ram_stream_fifo2 #(
        .CDataLen (CDataLen)
    ) uFifo (
        .AClkA     (AClkA),
        .AResetAN  (AResetAN),
        .AClkAEn   (AClkAEn),
        .APush     (rInFlight),
        .APushData (ABus.ARamMiso),
        .APop      (pop),
        .AHeadData (fifoHead),
        .ACount    (fifoCount)
    );

    assign ABus.ARamAddr  = rAddr;
    assign ABus.ARamRdEn  = issue;
    assign ABus.ARamWrEn  = 1'b0;
    assign ABus.ARamMosi  = '0;
    assign ABus.AStrData  = fifoHead;
    assign ABus.AStrValid = strValid;
    assign ABusy          = rBusy;
    assign ADone          = rDone;
endmodule

// File: tb/tb_ram_stream_rd.sv
module tb_ram_stream_rd;
    import ram_stream_pkg::*;

    logic        AClkA = 1'b0;
    logic        AResetAN = 1'b0;
    logic        AClkAEn = 1'b1;
    logic        ACmdStart = 1'b0;
    logic [10:0] ACmdAddr = '0;
    logic [11:0] ACmdLen = '0;
    logic        ABusy;
    logic        ADone;

    ram_stream_rd_if #(.CAddrLen(11), .CDataLen(8)) bus ();

    ram_stream_rd #(.CAddrLen(11), .CDataLen(8)) dut (
        .AClkA     (AClkA),
        .AResetAN  (AResetAN),
        .AClkAEn   (AClkAEn),
        .ACmdStart (ACmdStart),
        .ACmdAddr  (ACmdAddr),
        .ACmdLen   (ACmdLen),
        .ABusy     (ABusy),
        .ADone     (ADone),
        .ABus      (bus)
    );

    always #5 AClkA = ~AClkA;

    // RAM model: one-cycle read latency, shares the clock enable; mem[a] = a[7:0] + 0x90.
    logic [7:0] mem [2048];
    logic [7:0] ramQ = '0;
    always @(posedge AClkA) begin
        if (AClkAEn && bus.ARamRdEn) ramQ <= mem[bus.ARamAddr];
    end
    assign bus.ARamMiso = ramQ;

    typedef struct {
        logic [10:0]     addr;
        logic [11:0]     len;
        logic [31:0]     rdyPat;   // bit k = AStrReady in cycle k
        logic [31:0]     enPat;    // bit k = AClkAEn in cycle k
        int              strobeCyc; // cycle with a stray ACmdStart (0 = none)
        logic [3:0][7:0] expW;
        int              expFirst;
        int              expDone;
    } vec_t;

    int nChecks = 0;
    int nFails  = 0;
    int curVec  = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s (vector %0d): got %0d (0x%0h), expected %0d (0x%0h)",
                     name, curVec, act, act, exp, exp);
        end
    endtask

    task automatic runXfer(input vec_t v, input int abortAfter);
        int rdCnt = 0, accCnt = 0, doneCnt = 0, doneCyc = 0, firstCyc = 0;
        int addrErr = 0, busyErr = 0, stabErr = 0, maxOut = 0;
        logic prevHold = 1'b0;
        logic [7:0] prevData = '0;
        int got [8];
        logic [10:0] expAddr;
        @(negedge AClkA);
        AClkAEn = 1'b1;
        AStrReadySet(1'b1);
        ACmdStart = 1'b1;
        ACmdAddr = v.addr;
        ACmdLen = v.len;
        @(posedge AClkA);  // edge 0
        #1;
        ACmdStart = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            AStrReadySet(v.rdyPat[k]);
            AClkAEn = v.enPat[k];
            if (k == v.strobeCyc) begin
                ACmdStart = 1'b1;
                ACmdAddr = 11'h300;
                ACmdLen = 12'd7;
            end
            @(negedge AClkA);
            if (ABusy != (k <= v.expDone)) busyErr++;
            if (ADone) begin
                doneCnt++;
                if (doneCyc == 0) doneCyc = k;
            end
            if (prevHold && (!bus.AStrValid || bus.AStrData != prevData)) stabErr++;
            if (bus.ARamRdEn && AClkAEn) begin
                expAddr = v.addr + 11'(rdCnt);
                if (bus.ARamAddr != expAddr) addrErr++;
                rdCnt++;
            end
            if (bus.AStrValid && bus.AStrReady && AClkAEn) begin
                if (accCnt < 8) got[accCnt] = int'(bus.AStrData);
                if (accCnt == 0) firstCyc = k;
                accCnt++;
            end
            if (rdCnt - accCnt > maxOut) maxOut = rdCnt - accCnt;
            prevHold = bus.AStrValid && !(bus.AStrReady && AClkAEn);
            prevData = bus.AStrData;
            if (abortAfter != 0 && accCnt == abortAfter) return;
            @(posedge AClkA);
            #1;
            ACmdStart = 1'b0;
        end
        AClkAEn = 1'b1;
        check("word_count", accCnt, int'(v.len));
        for (int j = 0; j < 4; j++) begin
            if (j < int'(v.len) && j < accCnt) check("word_data", got[j], int'(v.expW[j]));
        end
        check("first_word_cycle", firstCyc, v.expFirst);
        check("done_cycle", doneCyc, v.expDone);
        check("done_pulses", doneCnt, 1);
        check("read_pulses", rdCnt, int'(v.len));
        check("read_addr_errors", addrErr, 0);
        check("busy_profile_errors", busyErr, 0);
        check("stall_stability_errors", stabErr, 0);
        check("outstanding_le_2", int'(maxOut <= 2), 1);
    endtask

    task automatic AStrReadySet(input logic r);
        bus.AStrReady = r;
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, "_busy"}, int'(ABusy), 0);
        check({name, "_done"}, int'(ADone), 0);
        check({name, "_ramaddr"}, int'(bus.ARamAddr), 0);
        check({name, "_rden"}, int'(bus.ARamRdEn), 0);
        check({name, "_wren"}, int'(bus.ARamWrEn), 0);
        check({name, "_mosi"}, int'(bus.ARamMosi), 0);
        check({name, "_strdata"}, int'(bus.AStrData), 0);
        check({name, "_strvalid"}, int'(bus.AStrValid), 0);
    endtask

    vec_t vecs [7];
    vec_t abortV;
    vec_t afterV;

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = 8'(a) + 8'h90;
        bus.AStrReady = 1'b0;

        vecs[0] = '{addr:11'h010, len:12'd4, rdyPat:32'hFFFF_FFFF, enPat:32'hFFFF_FFFF,
                    strobeCyc:0, expW:{8'hA3, 8'hA2, 8'hA1, 8'hA0}, expFirst:3, expDone:7};
        vecs[1] = '{addr:11'h7FE, len:12'd4, rdyPat:32'hFFFF_FFFF, enPat:32'hFFFF_FFFF,
                    strobeCyc:0, expW:{8'h91, 8'h90, 8'h8F, 8'h8E}, expFirst:3, expDone:7};
        // Ready low in cycles 4, 5, 7: words accepted in cycles 3, 6, 8, 9.
        vecs[2] = '{addr:11'h010, len:12'd4, rdyPat:32'hFFFF_FF4F, enPat:32'hFFFF_FFFF,
                    strobeCyc:0, expW:{8'hA3, 8'hA2, 8'hA1, 8'hA0}, expFirst:3, expDone:10};
        // Enable low in cycles 4..6: everything after shifts by 3.
        vecs[3] = '{addr:11'h010, len:12'd4, rdyPat:32'hFFFF_FFFF, enPat:32'hFFFF_FF8F,
                    strobeCyc:0, expW:{8'hA3, 8'hA2, 8'hA1, 8'hA0}, expFirst:3, expDone:10};
        vecs[4] = '{addr:11'h123, len:12'd0, rdyPat:32'hFFFF_FFFF, enPat:32'hFFFF_FFFF,
                    strobeCyc:0, expW:'0, expFirst:0, expDone:1};
        vecs[5] = '{addr:11'h005, len:12'd1, rdyPat:32'hFFFF_FFFF, enPat:32'hFFFF_FFFF,
                    strobeCyc:0, expW:{24'h0, 8'h95}, expFirst:3, expDone:4};
        // Stray start in cycle 2 (Run) must be ignored.
        vecs[6] = '{addr:11'h010, len:12'd4, rdyPat:32'hFFFF_FFFF, enPat:32'hFFFF_FFFF,
                    strobeCyc:2, expW:{8'hA3, 8'hA2, 8'hA1, 8'hA0}, expFirst:3, expDone:7};
        abortV  = '{addr:11'h000, len:12'd8, rdyPat:32'hFFFF_FFFF, enPat:32'hFFFF_FFFF,
                    strobeCyc:0, expW:'0, expFirst:3, expDone:11};
        afterV  = '{addr:11'h100, len:12'd2, rdyPat:32'hFFFF_FFFF, enPat:32'hFFFF_FFFF,
                    strobeCyc:0, expW:{16'h0, 8'h91, 8'h90}, expFirst:3, expDone:5};

        repeat (3) @(posedge AClkA);
        #1;
        curVec = -1;
        checkResetOutputs("reset");
        @(negedge AClkA);
        AResetAN = 1'b1;
        @(posedge AClkA);
        #1;

        for (int i = 0; i < 7; i++) begin
            curVec = i;
            runXfer(vecs[i], 0);
        end

        // Reset in the middle of an 8-word transfer after 2 accepted words.
        curVec = 7;
        runXfer(abortV, 2);
        #1;
        AResetAN = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(negedge AClkA);
        AResetAN = 1'b1;
        @(posedge AClkA);
        #1;
        curVec = 8;
        runXfer(afterV, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/ram_stream_rd.md
# ram_stream_rd

Read-side initiator for one port of the dual-port RAM model: accepts a (start address, length) command, issues sequential reads on the RAM port with correct one-cycle read latency, and delivers the words on a valid/ready stream with full backpressure support. Sits between a RAM port (A or B) and any streaming consumer (DMA, serializer, debug dump). Sustains one word per clock when the consumer is always ready.

## Interface
- CAddrLen, 11, RAM address width; must match the attached RAM.
- CDataLen, 8, RAM data width; must match the attached RAM.
- AClkA  in  1  clock; same clock as the attached RAM port.
- AResetAN  in  1  reset, asynchronous, active-low.
- AClkAEn  in  1  clock enable; must be the same signal driving the RAM port enable; low freezes all state.
- ACmdStart  in  1  command strobe; accepted only in Idle.
- ACmdAddr  in  CAddrLen  first word address.
- ACmdLen  in  CAddrLen+1  word count, 0..2^CAddrLen.
- ABusy  out  1  high in every state except Idle.
- ADone  out  1  one-cycle pulse when the last word has been accepted by the consumer.
- ARamAddr  out  CAddrLen  RAM address.
- ARamRdEn  out  1  RAM read enable.
- ARamWrEn  out  1  constant 0.
- ARamMosi  out  CDataLen  constant 0.
- ARamMiso  in  CDataLen  RAM read data.
- AStrData  out  CDataLen  stream data.
- AStrValid  out  1  stream valid.
- AStrReady  in  1  stream ready.

## Operation
- States: Idle, Run, Drain, Done.
- Idle: ACmdStart=1 with ACmdLen≠0 → load address counter and remaining counter, go to Run. ACmdLen=0 → go directly to Done, no RAM reads.
- Run: a read is issued in a cycle (ARamRdEn=1, ARamAddr=current address) when FCount + FInFlight − BPop < 2, where FCount = output FIFO occupancy (0..2), FInFlight = read issued in the previous enabled cycle, BPop = AStrValid & AStrReady. Each issue increments the address (mod 2^CAddrLen, wraps from all-ones to 0) and decrements the remaining count. Issue of the last word → Drain.
- Drain: no issues; when FCount=0, FInFlight=0 and no pop pending → Done.
- Done: ADone=1 for one cycle → Idle.
- ACmdStart outside Idle is ignored; command inputs are sampled only on acceptance.
- In-flight capture: when FInFlight=1, ARamMiso is pushed into the FIFO at the next enabled edge; the issue rule guarantees the FIFO is never full at that edge.
- Stream: AStrValid = FCount≠0; AStrData = FIFO head. Data is held stable while AStrValid=1 and AStrReady=0. Words emerge in address order, with none lost or duplicated.
- AClkAEn=0: no state, counter, or FIFO change; outputs hold. A ready/valid handshake counts only on an enabled edge.
- Reset (anytime, including mid-transfer): state Idle, counters 0, FIFO empty, FInFlight 0; the partial transfer is discarded.
- Reset values: ABusy 0, ADone 0, ARamAddr 0, ARamRdEn 0, ARamWrEn 0, ARamMosi 0, AStrData 0, AStrValid 0.

## Timing
- Start accepted at edge 0 → ARamRdEn=1 with ACmdAddr in cycle 1 → RAM latches at edge 1 → ARamMiso valid in cycle 2 → FIFO push at edge 2 → AStrValid=1 in cycle 3.
- With AStrReady held 1: one word per cycle, with N words on cycles 3..N+2. ADone is high in cycle N+3, and ABusy falls after it.
- ACmdLen=0: ADone in cycle 1, with no ARamRdEn pulse.
- With AStrReady=0, at most 2 words are buffered. Issue stops within 1 cycle, and no RAM read is issued whose data cannot be stored.
- All outputs are registered except AStrValid/AStrData (FIFO register outputs) and ARamRdEn/ARamAddr, which may be a combinational decode of registered state and the BPop term.

## Structure
- Package ram_stream_pkg: state enum (Idle, Run, Drain, Done), constant CFifoDepth=2.
- Sub-module ram_stream_fifo2: 2-entry FIFO with push/pop/count, async active-low reset, and clock enable. It is instantiated once for the output buffer.
- Top level: FSM, address counter, remaining counter, in-flight flag, issue logic.

## Test plan
- ACmdAddr=0x010, ACmdLen=4, RAM preloaded with 0xA0+i, AStrReady=1 → stream 0xA0..0xA3 on cycles 3..6, ADone in cycle 7, exactly 4 ARamRdEn pulses.
- ACmdAddr=0x7FE, ACmdLen=4 → reads at 0x7FE, 0x7FF, 0x000, 0x001; data order matches.
- Same as the first scenario with AStrReady toggling 1,0,0,1,0,1… → identical 4-word sequence, data stable while stalled, FIFO count never exceeds 2, ADone after the 4th accepted word.
- ACmdLen=0 → ADone in cycle 1, ABusy high for exactly that cycle, no RAM reads; ACmdStart during Run → ignored, transfer unchanged.
- AResetAN low after 2 of 8 words → all outputs at reset values immediately; new command ACmdAddr=0x100, ACmdLen=2 runs cleanly.
- AClkAEn low for 3 cycles mid-transfer (RAM sharing the enable) → no words lost or duplicated; total latency extends by exactly 3 cycles.
